// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings and FSM state type for the universal shift register
package usr_pkg;
    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHR  = 3'b001;
    localparam logic [2:0] USR_SHL  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROTR = 3'b100;
    localparam logic [2:0] USR_ROTL = 3'b101;
    localparam logic [2:0] USR_ASHR = 3'b110;
    localparam logic [2:0] USR_CLR  = 3'b111;

    typedef enum logic {IDLE, BURST} usr_state_t;
endpackage

// File: rtl/usr_next_value.sv
// usr_next_value: combinational next-register-value for every shift mode
module usr_next_value
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] in,
    input  logic             sir,
    input  logic             sil,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] nxt
);
    // select the next value for the requested operation
    always_comb begin
        nxt = cur;
        case (mode)
            USR_SHR:  nxt = {sir, cur[WIDTH-1:1]};
            USR_SHL:  nxt = {cur[WIDTH-2:0], sil};
            USR_LOAD: nxt = in;
            USR_ROTR: nxt = {cur[0], cur[WIDTH-1:1]};
            USR_ROTL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            USR_ASHR: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            USR_CLR:  nxt = '0;
            default:  nxt = cur;
        endcase
    end
endmodule

// File: rtl/param_universal_shift_reg.sv
// param_universal_shift_reg: WIDTH-bit universal shift register with counted burst engine
// Optional USR_PARITY_EN adds a registered even-parity output of out.
module param_universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic             sir,
    input  logic             sil,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out,
    output logic             sor,
    output logic             sol,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);
    usr_state_t       state, state_d;
    logic [CNT_W-1:0] rem, rem_d;
    logic [2:0]       mode_q, mode_q_d, op;
    logic             apply, done_d;
    logic [WIDTH-1:0] nxt, out_d;

    usr_next_value #(.WIDTH(WIDTH)) u_next (
        .cur  (out),
        .in   (in),
        .sir  (sir),
        .sil  (sil),
        .mode (op),
        .nxt  (nxt)
    );

    // next-state, burst counter and which mode drives the register this cycle
    always_comb begin
        state_d  = state;
        rem_d    = rem;
        mode_q_d = mode_q;
        done_d   = 1'b0;
        op       = mode;
        apply    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d  = BURST;
                        rem_d    = count;
                        mode_q_d = mode;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    apply = en;
                end
            end
            BURST: begin
                op    = mode_q;
                apply = 1'b1;
                rem_d = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_d = apply ? nxt : out;

    // register state, counter, latched burst mode, data and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            mode_q <= USR_HOLD;
            out    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            rem    <= rem_d;
            mode_q <= mode_q_d;
            out    <= out_d;
            done   <= done_d;
        end
    end

`ifdef USR_PARITY_EN
    // parity tracks the value being written into out on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity <= 1'b0;
        else        parity <= ^out_d;
    end
`endif

    assign busy = (state == BURST);
    assign sor  = out[0];
    assign sol  = out[WIDTH-1];
endmodule

// File: tb/tb_param_universal_shift_reg.sv
// tb_param_universal_shift_reg: directed table and sequence checks for the shift register
module tb_param_universal_shift_reg;
    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  in = '0;
    logic          sir = 1'b0;
    logic          sil = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  out;
    logic          sor, sol, busy, done;
`ifdef USR_PARITY_EN
    logic          parity;
`endif

    int checks = 0;
    int errors = 0;

    param_universal_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .in    (in),
        .sir   (sir),
        .sil   (sil),
        .start (start),
        .count (count),
        .out   (out),
        .sor   (sor),
        .sol   (sol),
        .busy  (busy),
        .done  (done)
`ifdef USR_PARITY_EN
        ,
        .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] in;
        logic         sir;
        logic         sil;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [W-1:0] d,
                         input logic r, input logic l, input logic s, input logic [CW-1:0] c);
        en = e; mode = m; in = d; sir = r; sil = l; start = s; count = c;
    endtask

    task automatic state_chk(input string name, input logic [W-1:0] eo, input logic eb, input logic ed);
        chk({name, "_out"}, 32'(out), 32'(eo));
        chk({name, "_busy"}, 32'(busy), 32'(eb));
        chk({name, "_done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'hD2};
        vecs[2]  = '{1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[3]  = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'h4A};
        vecs[4]  = '{1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h4A};
        vecs[5]  = '{1'b1, 3'b000, 8'h00, 1'b1, 1'b1, 8'h4A};
        vecs[6]  = '{1'b1, 3'b000, 8'h33, 1'b0, 1'b1, 8'h4A};
        vecs[7]  = '{1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 8'h4A};
        vecs[8]  = '{1'b0, 3'b011, 8'h00, 1'b1, 1'b1, 8'h4A};
        vecs[9]  = '{1'b1, 3'b100, 8'h00, 1'b1, 1'b1, 8'h25};
        vecs[10] = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h4A};
        vecs[11] = '{1'b1, 3'b110, 8'h00, 1'b1, 1'b1, 8'h25};
        vecs[12] = '{1'b1, 3'b111, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[13] = '{1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[14] = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'h03};
        vecs[15] = '{1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h01};

        #12;
        state_chk("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        state_chk("post_reset_idle", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].in, vecs[i].sir, vecs[i].sil, 1'b0, '0);
            step();
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_sor", i), 32'(sor), 32'(vecs[i].exp[0]));
            chk($sformatf("vec%0d_sol", i), 32'(sol), 32'(vecs[i].exp[W-1]));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
`ifdef USR_PARITY_EN
            chk($sformatf("vec%0d_parity", i), 32'(parity), 32'(^vecs[i].exp));
`endif
        end

        drive(1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
        step();
        drive(1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        step();
        state_chk("rot_e0", 8'hA5, 1'b1, 1'b0);
        drive(1'b1, 3'b111, 8'h00, 1'b1, 1'b1, 1'b0, '0);
        step();
        state_chk("rot_e1", 8'hD2, 1'b1, 1'b0);
        drive(1'b1, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("rot_e2", 8'h69, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("rot_e3", 8'hB4, 1'b0, 1'b1);
        chk("rot_sor", 32'(sor), 32'd0);
        chk("rot_sol", 32'(sol), 32'd1);
        step();
        state_chk("rot_after", 8'hB4, 1'b0, 1'b0);

        drive(1'b1, 3'b011, 8'h90, 1'b0, 1'b0, 1'b0, '0);
        step();
        drive(1'b0, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4);
        step();
        state_chk("ashr_e0", 8'h90, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("ashr_e1", 8'hC8, 1'b1, 1'b0);
        step();
        state_chk("ashr_e2", 8'hE4, 1'b1, 1'b0);
        step();
        state_chk("ashr_e3", 8'hF2, 1'b1, 1'b0);
        step();
        state_chk("ashr_e4", 8'hF9, 1'b0, 1'b1);

        drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
        step();
        state_chk("cnt0_e0", 8'hF9, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("cnt0_e1", 8'hF9, 1'b0, 1'b0);

        drive(1'b1, 3'b011, 8'h01, 1'b0, 1'b0, 1'b0, '0);
        step();
        drive(1'b0, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
        step();
        state_chk("drop_e0", 8'h01, 1'b1, 1'b0);
        drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
        step();
        state_chk("drop_e1", 8'h02, 1'b1, 1'b0);
        drive(1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("drop_e2", 8'h04, 1'b0, 1'b1);
        drive(1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1);
        step();
        state_chk("b2b_e0", 8'h04, 1'b1, 1'b0);
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("b2b_e1", 8'h08, 1'b0, 1'b1);

        drive(1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
        step();
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("rstb_e1", 8'h04, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        state_chk("rst_async", 8'h00, 1'b0, 1'b0);
        step();
        #3;
        rst_n = 1'b1;
        drive(1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, '0);
        step();
        state_chk("rst_release", 8'h00, 1'b0, 1'b0);
        step();
        state_chk("rst_hold", 8'h00, 1'b0, 1'b0);

`ifdef USR_PARITY_EN
        drive(1'b1, 3'b011, 8'h07, 1'b0, 1'b0, 1'b0, '0);
        step();
        chk("parity_07", 32'(parity), 32'd1);
        drive(1'b1, 3'b011, 8'h03, 1'b0, 1'b0, 1'b0, '0);
        step();
        chk("parity_03", 32'(parity), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
